pe_accumulator: RTL



---
 rtl/pe_accumulator.sv | 116 +++++++++++
 1 files changed

// File: rtl/pe_accumulator.sv
// Sums one product segment (closed by in_last or K_MAX terms) and presents the result 1 cycle after the closing beat.
// A held result stalls input until out_ready; define PE_ACC_SAT_EN to saturate on overflow instead of wrapping.
module pe_accumulator #(
  parameter int          WIDTH_MUL = 32,
  parameter int          WIDTH_ACC = 40,
  parameter int unsigned SIGNED    = 0,
  parameter int          K_MAX     = 256,
  parameter int          WIDTH_K   = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pip_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_MUL-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_ACC-1:0] out_data,
  output logic [WIDTH_K-1:0]   out_count,
  output logic                 out_ovf,
  output logic                 out_trunc,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [WIDTH_K-1:0] K_LIM = WIDTH_K'(K_MAX);
  localparam int                 MSB   = WIDTH_ACC - 1;

  state_t               state, state_nxt;
  logic [WIDTH_ACC-1:0] acc, acc_nxt, acc_add, prod_ext, sum;
  logic [WIDTH_K-1:0]   cnt, cnt_nxt;
  logic                 ovf, ovf_nxt, add_ovf, carry;
  logic                 accept, consume, close_seg, trunc_nxt;

  assign prod_ext     = {{(WIDTH_ACC-WIDTH_MUL){(SIGNED != 0) & in_data[WIDTH_MUL-1]}}, in_data};
  assign {carry, sum} = {1'b0, acc} + {1'b0, prod_ext};
  assign add_ovf      = (SIGNED != 0) ? ((acc[MSB] == prod_ext[MSB]) & (sum[MSB] != acc[MSB]))
                                      : carry;

`ifdef PE_ACC_SAT_EN
  // The rail follows the operands' shared sign; unsigned sums can only overflow upward.
  assign acc_add = !add_ovf        ? sum :
                   (SIGNED != 0)   ? {acc[MSB], {MSB{~acc[MSB]}}} : '1;
`else
  assign acc_add = sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Any accept outside ACC opens a new segment (IDLE, or HOLD while its result drains).
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    close_seg = 1'b0;
    trunc_nxt = 1'b0;
    if (accept) begin
      if (state != ACC) begin
        acc_nxt = prod_ext;
        cnt_nxt = WIDTH_K'(1);
        ovf_nxt = 1'b0;
      end else begin
        acc_nxt = acc_add;
        cnt_nxt = cnt + WIDTH_K'(1);
        ovf_nxt = ovf | add_ovf;
      end
      close_seg = in_last | (cnt_nxt == K_LIM);
      trunc_nxt = ~in_last & (cnt_nxt == K_LIM);
      state_nxt = close_seg ? HOLD : ACC;
    end else if (consume) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    in_ready = pip_en & ((state != HOLD) | out_ready);
    busy     = (state != IDLE);
    accept   = in_valid & in_ready;
    consume  = out_valid & out_ready & pip_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      if (accept) begin
        acc <= acc_nxt;
        cnt <= close_seg ? '0 : cnt_nxt;
        ovf <= ovf_nxt;
      end
      if (accept && close_seg) begin
        out_valid <= 1'b1;
        out_data  <= acc_nxt;
        out_count <= cnt_nxt;
        out_ovf   <= ovf_nxt;
        out_trunc <= trunc_nxt;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
